// File: rtl/cluster_pkg.sv
// Shared widths, FSM state encodings and helpers for the point-clustering blocks.
package cluster_pkg;

    localparam int unsigned ADDR_W  = 4;
    localparam int unsigned COORD_W = 8;
    localparam int unsigned LABEL_W = 4;
    localparam int unsigned DIST_W  = 18;

    // Controller states
    localparam logic [2:0] StIdle  = 3'd0;
    localparam logic [2:0] StInit  = 3'd1;
    localparam logic [2:0] StScan  = 3'd2;
    localparam logic [2:0] StCheck = 3'd3;
    localparam logic [2:0] StDone  = 3'd4;

    // Absolute difference of two unsigned coordinates
    function automatic logic [COORD_W-1:0] abs_diff(input logic [COORD_W-1:0] a,
                                                    input logic [COORD_W-1:0] b);
        return (a > b) ? (a - b) : (b - a);
    endfunction

endpackage

// File: rtl/cluster_engine_sq_dist3.sv
// Combinational 3-axis squared Euclidean distance between two 8-bit points.
module sq_dist3
    import cluster_pkg::*;
(
    input  logic [COORD_W-1:0] xa,
    input  logic [COORD_W-1:0] ya,
    input  logic [COORD_W-1:0] za,
    input  logic [COORD_W-1:0] xb,
    input  logic [COORD_W-1:0] yb,
    input  logic [COORD_W-1:0] zb,
    output logic [DIST_W-1:0]  d2
);

    logic [COORD_W-1:0]   dx, dy, dz;
    logic [2*COORD_W-1:0] sx, sy, sz;

    // Three squares of at most 255^2 sum to 195075, which fits 18 bits
    always_comb begin
        dx = abs_diff(xa, xb);
        dy = abs_diff(ya, yb);
        dz = abs_diff(za, zb);
        sx = dx * dx;
        sy = dy * dy;
        sz = dz * dz;
        d2 = DIST_W'(sx) + DIST_W'(sy) + DIST_W'(sz);
    end

endmodule

// File: rtl/cluster_engine.sv
// Label-propagation controller: initialises labels, then sweeps all point pairs
// merging labels of nearby points until a pass makes no change or the pass limit hits.
module cluster_engine
    import cluster_pkg::*;
#(
    parameter int unsigned       N         = 16,
    parameter logic [DIST_W-1:0] THRESH_SQ = 18'd400,
    parameter int unsigned       MAX_PASS  = 8
) (
    input  logic               clk,
    input  logic               rst_n,
    input  logic               start,
    output logic [ADDR_W-1:0]  raddr_i,
    output logic [ADDR_W-1:0]  raddr_j,
    input  logic [COORD_W-1:0] xi,
    input  logic [COORD_W-1:0] yi,
    input  logic [COORD_W-1:0] zi,
    input  logic [COORD_W-1:0] xj,
    input  logic [COORD_W-1:0] yj,
    input  logic [COORD_W-1:0] zj,
    input  logic [LABEL_W-1:0] li,
    input  logic [LABEL_W-1:0] lj,
    output logic               we,
    output logic [ADDR_W-1:0]  waddr,
    output logic [LABEL_W-1:0] wlabel,
    output logic               busy,
    output logic               done,
    output logic               no_conv,
    output logic [4:0]         pass_count
);

    localparam logic [ADDR_W-1:0] LastIdx = ADDR_W'(N - 1);
    localparam logic [ADDR_W-1:0] LastI   = ADDR_W'(N - 2);
    localparam logic [4:0]        MaxPass = 5'(MAX_PASS);

    logic [2:0]        state_q, state_d;
    logic [ADDR_W-1:0] i_q, i_d, j_q, j_d, k_q, k_d;
    logic [4:0]        pass_q, pass_d;
    logic              changed_q, changed_d;
    logic              no_conv_q, no_conv_d;
    logic [DIST_W-1:0] d2;
    logic              hit;

    sq_dist3 u_dist (
        .xa (xi),
        .ya (yi),
        .za (zi),
        .xb (xj),
        .yb (yj),
        .zb (zj),
        .d2 (d2)
    );

    assign hit = (d2 <= THRESH_SQ) && (li != lj);

    // Next-state logic: FSM, pair/init counters, pass counter and flags
    always_comb begin
        state_d   = state_q;
        i_d       = i_q;
        j_d       = j_q;
        k_d       = k_q;
        pass_d    = pass_q;
        changed_d = changed_q;
        no_conv_d = no_conv_q;
        case (state_q)
            StIdle: begin
                if (start) begin
                    state_d   = StInit;
                    k_d       = '0;
                    pass_d    = '0;
                    no_conv_d = 1'b0;
                    changed_d = 1'b0;
                end
            end
            StInit: begin
                k_d = k_q + 1'b1;
                if (k_q == LastIdx) begin
                    state_d = StScan;
                    k_d     = '0;
                    i_d     = '0;
                    j_d     = ADDR_W'(1);
                end
            end
            StScan: begin
                if (hit) changed_d = 1'b1;
                if (j_q == LastIdx) begin
                    if (i_q == LastI) begin
                        pass_d  = pass_q + 1'b1;
                        state_d = StCheck;
                    end else begin
                        i_d = i_q + 1'b1;
                        j_d = i_q + ADDR_W'(2);
                    end
                end else begin
                    j_d = j_q + 1'b1;
                end
            end
            StCheck: begin
                if (!changed_q) begin
                    state_d = StDone;
                end else if (pass_q == MaxPass) begin
                    no_conv_d = 1'b1;
                    state_d   = StDone;
                end else begin
                    changed_d = 1'b0;
                    state_d   = StScan;
                    i_d       = '0;
                    j_d       = ADDR_W'(1);
                end
            end
            StDone:  state_d = StIdle;
            default: state_d = StIdle;
        endcase
    end

    // State registers with synchronous active-low reset
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q   <= StIdle;
            i_q       <= '0;
            j_q       <= '0;
            k_q       <= '0;
            pass_q    <= '0;
            changed_q <= 1'b0;
            no_conv_q <= 1'b0;
        end else begin
            state_q   <= state_d;
            i_q       <= i_d;
            j_q       <= j_d;
            k_q       <= k_d;
            pass_q    <= pass_d;
            changed_q <= changed_d;
            no_conv_q <= no_conv_d;
        end
    end

    // Label write port: identity labels in INIT, merge toward the smaller label in SCAN
    always_comb begin
        we     = 1'b0;
        waddr  = '0;
        wlabel = '0;
        if (state_q == StInit) begin
            we     = 1'b1;
            waddr  = k_q;
            wlabel = k_q;
        end else if ((state_q == StScan) && hit) begin
            we     = 1'b1;
            waddr  = (li > lj) ? i_q : j_q;
            wlabel = (li < lj) ? li : lj;
        end
    end

    assign raddr_i    = i_q;
    assign raddr_j    = j_q;
    assign busy       = (state_q == StInit) || (state_q == StScan) || (state_q == StCheck);
    assign done       = (state_q == StDone);
    assign no_conv    = no_conv_q;
    assign pass_count = pass_q;

endmodule

// File: tb/tb_cluster_engine.sv
// Directed bench: three engines (thresholds 25/24/0, pass limits 8/8/1) each with
// its own label memory, sharing one coordinate table.
module tb_cluster_engine;

    logic       clk = 1'b0;
    logic       rst_n = 1'b0;
    logic [2:0] start = 3'b000;

    logic [7:0] x_mem [16];
    logic [7:0] y_mem [16];
    logic [7:0] z_mem [16];

    logic [3:0] raddr_i_w [3];
    logic [3:0] raddr_j_w [3];
    logic [3:0] waddr_w   [3];
    logic [3:0] wlabel_w  [3];
    logic [4:0] pass_w    [3];
    logic       we_w      [3];
    logic       busy_w    [3];
    logic       done_w    [3];
    logic       no_conv_w [3];

    int errors = 0;
    int checks = 0;

    always #5 clk = ~clk;

    for (genvar g = 0; g < 3; g++) begin : gi
        logic [3:0] lab [16];

        cluster_engine #(
            .N         (16),
            .THRESH_SQ ((g == 0) ? 18'd25 : ((g == 1) ? 18'd24 : 18'd0)),
            .MAX_PASS  ((g == 2) ? 1 : 8)
        ) dut (
            .clk        (clk),
            .rst_n      (rst_n),
            .start      (start[g]),
            .raddr_i    (raddr_i_w[g]),
            .raddr_j    (raddr_j_w[g]),
            .xi         (x_mem[raddr_i_w[g]]),
            .yi         (y_mem[raddr_i_w[g]]),
            .zi         (z_mem[raddr_i_w[g]]),
            .xj         (x_mem[raddr_j_w[g]]),
            .yj         (y_mem[raddr_j_w[g]]),
            .zj         (z_mem[raddr_j_w[g]]),
            .li         (lab[raddr_i_w[g]]),
            .lj         (lab[raddr_j_w[g]]),
            .we         (we_w[g]),
            .waddr      (waddr_w[g]),
            .wlabel     (wlabel_w[g]),
            .busy       (busy_w[g]),
            .done       (done_w[g]),
            .no_conv    (no_conv_w[g]),
            .pass_count (pass_w[g])
        );

        always @(posedge clk) begin
            if (we_w[g]) lab[waddr_w[g]] <= wlabel_w[g];
        end
    end

    task automatic check(input string tag, input int obs, input int exp);
        checks++;
        if (obs != exp) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d", tag, obs, exp);
        end
    endtask

    function automatic int get_lab(input int g, input int p);
        case (g)
            0:       return int'(gi[0].lab[p]);
            1:       return int'(gi[1].lab[p]);
            default: return int'(gi[2].lab[p]);
        endcase
    endfunction

    // mode 0: all coincident, 1: x=16k, 2: x=5k, 3: two clusters
    task automatic load(input int mode);
        for (int p = 0; p < 16; p++) begin
            case (mode)
                0: begin x_mem[p] = 8'd10; y_mem[p] = 8'd10; z_mem[p] = 8'd10; end
                1: begin x_mem[p] = 8'(16 * p); y_mem[p] = 8'd0; z_mem[p] = 8'd0; end
                2: begin x_mem[p] = 8'(5 * p); y_mem[p] = 8'd0; z_mem[p] = 8'd0; end
                default: begin
                    x_mem[p] = (p < 8) ? 8'd0 : 8'd200;
                    y_mem[p] = x_mem[p];
                    z_mem[p] = x_mem[p];
                end
            endcase
        end
    endtask

    // exp 0: all zero, 1: identity, 2: 0 for 0..7 and 8 for 8..15
    task automatic check_labels(input string tag, input int g, input int exp);
        int e;
        for (int p = 0; p < 16; p++) begin
            case (exp)
                0:       e = 0;
                1:       e = p;
                default: e = (p < 8) ? 0 : 8;
            endcase
            check($sformatf("%s lab[%0d]", tag, p), get_lab(g, p), e);
        end
    endtask

    // Starts engine g and counts busy/done cycles and writes until done.
    // poke_at re-pulses start at that cycle; reset_at aborts the run with a reset.
    task automatic run(input string tag, input int g, input int poke_at, input int reset_at,
                       output int cycles, output int we_cnt);
        bit done_seen = 1'b0;
        cycles = 0;
        we_cnt = 0;
        @(negedge clk);
        start[g] = 1'b1;
        @(negedge clk);
        start[g] = 1'b0;
        for (int t = 0; t < 2000 && !done_seen; t++) begin
            if (t > 0) @(negedge clk);
            if (busy_w[g] || done_w[g]) cycles++;
            if (we_w[g]) we_cnt++;
            if (done_w[g]) done_seen = 1'b1;
            start[g] = (t == poke_at);
            if (t == reset_at) begin
                rst_n = 1'b0;
                @(negedge clk);
                check({tag, " busy after reset"}, int'(busy_w[g]), 0);
                check({tag, " we after reset"}, int'(we_w[g]), 0);
                check({tag, " pass after reset"}, int'(pass_w[g]), 0);
                rst_n = 1'b1;
                return;
            end
        end
        if (!done_seen) begin
            check({tag, " timeout"}, 0, 1);
        end else begin
            @(negedge clk);
            check({tag, " done one cycle"}, int'(done_w[g]), 0);
            check({tag, " busy after done"}, int'(busy_w[g]), 0);
        end
    endtask

    initial begin
        int cyc, wec;
        load(0);
        repeat (3) @(negedge clk);
        check("rst raddr_i", int'(raddr_i_w[0]), 0);
        check("rst raddr_j", int'(raddr_j_w[0]), 0);
        check("rst we", int'(we_w[0]), 0);
        check("rst waddr", int'(waddr_w[0]), 0);
        check("rst wlabel", int'(wlabel_w[0]), 0);
        check("rst busy", int'(busy_w[0]), 0);
        check("rst done", int'(done_w[0]), 0);
        check("rst no_conv", int'(no_conv_w[0]), 0);
        check("rst pass", int'(pass_w[0]), 0);
        rst_n = 1'b1;

        // All coincident: two passes, 16 + 2*121 + 1 cycles
        run("coinc", 0, -1, -1, cyc, wec);
        check("coinc cycles", cyc, 259);
        check("coinc pass", int'(pass_w[0]), 2);
        check("coinc no_conv", int'(no_conv_w[0]), 0);
        check_labels("coinc", 0, 0);

        // All isolated: only the 16 INIT writes occur
        load(1);
        run("iso", 0, -1, -1, cyc, wec);
        check("iso cycles", cyc, 138);
        check("iso writes", wec, 16);
        check("iso pass", int'(pass_w[0]), 1);
        check_labels("iso", 0, 1);

        // Boundary chain: d2 = 25 merges at threshold 25, not at 24
        load(2);
        run("chain25", 0, -1, -1, cyc, wec);
        check("chain25 pass", int'(pass_w[0]), 2);
        check_labels("chain25", 0, 0);
        run("chain24", 1, -1, -1, cyc, wec);
        check("chain24 pass", int'(pass_w[1]), 1);
        check_labels("chain24", 1, 1);

        // Two clusters
        load(3);
        run("two", 0, -1, -1, cyc, wec);
        check("two cycles", cyc, 259);
        check("two pass", int'(pass_w[0]), 2);
        check_labels("two", 0, 2);

        // Pass limit of 1 with labels still changing
        load(0);
        run("limit", 2, -1, -1, cyc, wec);
        check("limit cycles", cyc, 138);
        check("limit no_conv", int'(no_conv_w[2]), 1);
        check("limit pass", int'(pass_w[2]), 1);
        check_labels("limit", 2, 0);

        // Start re-pulsed during SCAN is ignored
        load(3);
        run("poke", 0, 40, -1, cyc, wec);
        check("poke cycles", cyc, 259);
        check("poke pass", int'(pass_w[0]), 2);
        check_labels("poke", 0, 2);

        // Reset mid-SCAN, then a fresh run reproduces the result
        run("abort", 0, -1, 60, cyc, wec);
        run("rerun", 0, -1, -1, cyc, wec);
        check("rerun cycles", cyc, 259);
        check("rerun pass", int'(pass_w[0]), 2);
        check("rerun no_conv", int'(no_conv_w[0]), 0);
        check_labels("rerun", 0, 2);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/cluster_engine.md
# cluster_engine

Label-propagation controller that drives the `point_memory` read and label-write ports to cluster up to 16 LiDAR points by squared Euclidean distance. On `start`, it initialises every label to its own index. It then sweeps all pairs (i<j), one per cycle. When a pair lies within the threshold and carries different labels, it overwrites the larger label with the smaller. Passes repeat until a pass makes no change or the pass limit is reached.

## Interface
- `N`, 16: number of points; 2..16, since addresses are 4 bits.
- `THRESH_SQ`, 18'd400: inclusive squared-distance threshold.
- `MAX_PASS`, 8: maximum number of SCAN passes, 1..31.
- `clk` in 1: single clock, rising edge.
- `rst_n` in 1: synchronous, active-low reset.
- `start` in 1: begin a clustering run; sampled only in IDLE.
- `raddr_i`, `raddr_j` out 4: read addresses for the pair (i, j).
- `xi`, `yi`, `zi`, `xj`, `yj`, `zj` in 8 each: unsigned coordinates, combinational from memory.
- `li`, `lj` in 4: current labels, combinational from memory.
- `we` out 1: label write enable.
- `waddr` out 4: point whose label is written.
- `wlabel` out 4: label value written.
- `busy` out 1: high in INIT, SCAN and CHECK.
- `done` out 1: one-cycle pulse at the end of a run.
- `no_conv` out 1: valid with `done` and held until the next `start`; 1 means the pass limit was hit while labels were still changing.
- `pass_count` out 5: passes executed in the last run; held until the next `start`.

## Operation
- States: IDLE → INIT → SCAN ⇄ CHECK → DONE → IDLE.
- **IDLE:** `start`=1 moves to INIT and clears `pass_count`, `no_conv` and the changed flag.
- **INIT:** runs N cycles with k = 0..N-1, driving `we`=1, `waddr`=k, `wlabel`=k. After k=N-1 it moves to SCAN with i=0, j=1.
- **SCAN:** one pair per cycle in lexicographic order, (0,1),(0,2)…(0,N-1),(1,2)…(N-2,N-1). This is N(N-1)/2 cycles, 120 for N=16.
  - d2 = (|xi-xj|)² + (|yi-yj|)² + (|zi-zj|)².
  - Each difference is 8 bits, each square 16 bits, and the sum is 18 bits with no overflow; maximum 195075.
  - If d2 ≤ THRESH_SQ and li≠lj: `we`=1, `waddr` = (li>lj ? i : j), `wlabel` = min(li, lj), and the changed flag is set.
  - Otherwise `we`=0.
  - After the last pair, increment `pass_count` and go to CHECK.
- **CHECK:** one cycle.
  - If changed=0: go to DONE.
  - Else if `pass_count`==MAX_PASS: set `no_conv`=1 and go to DONE.
  - Else: clear changed and go to SCAN with i=0, j=1.
- **DONE:** one cycle with `done`=1, then IDLE.
- Writes land at the clock edge. Because memory reads are combinational, later pairs in the same pass see updated labels, so in-place propagation is intended.
- `start` asserted outside IDLE is ignored and not queued.
- Final labels: each cluster carries the minimum point index among its members.

## Timing
- Reset values: `raddr_i`=0, `raddr_j`=0, `we`=0, `waddr`=0, `wlabel`=0, `busy`=0, `done`=0, `no_conv`=0, `pass_count`=0, state IDLE.
- All outputs are registered or decoded from state/counters; no input-to-`we` path except the SCAN compare.
- `start` accepted at edge E0; `busy` is high from the cycle after E0.
- Run length for a run of P passes: N INIT cycles + P·(N(N-1)/2 + 1) SCAN/CHECK cycles + 1 DONE cycle.
  - N=16, P=2: 16 + 242 + 1 = 259 cycles.
- `busy` is 0 in the DONE cycle.
- Reset mid-run: next cycle is IDLE with `we`=0. Label memory is not cleared; the next run's INIT overwrites it.

## Structure
- Shared package `cluster_pkg`:
  - `ADDR_W`=4, `COORD_W`=8, `LABEL_W`=4, `DIST_W`=18.
  - State enum {IDLE, INIT, SCAN, CHECK, DONE}.
- Sub-module `sq_dist3`: purely combinational 3-axis squared-distance unit (six 8-bit inputs, one 18-bit output), reusable by future blocks.
- Top-level: FSM, i/j/k counters, pass counter, changed flag, write-select muxing.

## Test plan
- **All coincident:** all points at (10,10,10), THRESH_SQ=0 → all labels 0, `pass_count`=2, `no_conv`=0, `done` 259 cycles after `start`.
- **All isolated:** x=16·k, y=z=0, THRESH_SQ=100 → label k for point k, `pass_count`=1, `we` never high during SCAN.
- **Boundary chain:** x=5·k, y=z=0, THRESH_SQ=25 → all labels 0, since d2=25 is included. Rerun with THRESH_SQ=24 → labels k.
- **Two clusters:** points 0–7 at (0,0,0), points 8–15 at (200,200,200) → labels 0 for 0–7 and 8 for 8–15, `pass_count`=2.
- **Pass limit:** coincident set with MAX_PASS=1 → `no_conv`=1, `pass_count`=1.
- **Mid-run reset and ignored start:**
  - `start` pulsed again during SCAN → no effect.
  - `rst_n`=0 mid-SCAN → next cycle `busy`=0 and `we`=0.
  - A new `start` then reproduces the two-cluster result exactly.
